// File: rtl/mmio_led_pkg.sv
// rtl/mmio_led_pkg.sv - register map, reset values and helpers for mmio_led_ctrl
package mmio_led_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [2:0] OFS_OUT      = 3'd0;
  localparam logic [2:0] OFS_MODE     = 3'd1;
  localparam logic [2:0] OFS_PRESCALE = 3'd2;
  localparam logic [2:0] OFS_PERIOD   = 3'd3;
  localparam logic [2:0] OFS_STATUS   = 3'd4;
  localparam int         NUM_REGS     = 5;

  localparam byte_t RST_OUT      = 8'hFF;
  localparam byte_t RST_MODE     = 8'h00;
  localparam byte_t RST_PRESCALE = 8'h00;
  localparam byte_t RST_PERIOD   = 8'h00;

  function automatic byte_t status_byte(input logic phase);
    return {7'b0, phase};
  endfunction

endpackage

// File: rtl/mmio_led_ctrl_if.sv
// rtl/mmio_led_ctrl_if.sv - NoobsCPU data bus slice seen by the LED controller
interface mmio_led_ctrl_if;
  logic [10:0] m_addr;
  logic [7:0]  m_wr_data;
  logic [7:0]  m_rd_data;
  logic        m_rd;
  logic        m_wr;
  logic        m_en;

  modport master (output m_addr, m_wr_data, m_rd, m_wr, m_en, input m_rd_data);
  modport slave  (input m_addr, m_wr_data, m_rd, m_wr, m_en, output m_rd_data);
endinterface

// File: rtl/led_timebase.sv
// rtl/led_timebase.sv - shared blink timebase: prescaler tick and half-period phase
module led_timebase #(
  parameter int PRE_W = 16
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [7:0] i_prescale,
  input  logic [7:0] i_period,
  input  logic       i_restart,
  output logic       o_tick,
  output logic       o_phase
);

  localparam logic [PRE_W-1:0] LOW_ONES = PRE_W'((1 << (PRE_W - 8)) - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic [PRE_W-1:0] w_match;
  logic [7:0]       r_per_cnt;
  logic             r_phase;

  // Terminal count is PRESCALE in the top byte with all lower bits set.
  assign w_match = (PRE_W'(i_prescale) << (PRE_W - 8)) | LOW_ONES;
  assign o_tick  = (r_pre_cnt == w_match);
  assign o_phase = r_phase;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_pre_cnt <= '0;
      r_per_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (i_restart) begin
      r_pre_cnt <= '0;
      r_per_cnt <= '0;
      r_phase   <= 1'b0;
    end else begin
      r_pre_cnt <= o_tick ? '0 : r_pre_cnt + PRE_W'(1);
      if (o_tick) begin
        if (r_per_cnt == i_period) begin
          r_per_cnt <= '0;
          r_phase   <= ~r_phase;
        end else begin
          r_per_cnt <= r_per_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mmio_led_ctrl.sv
// rtl/mmio_led_ctrl.sv - MMIO LED controller: decode, registers, readback, led register
// Readback of offsets 0..4 exists only when MMIO_LED_READBACK_EN is defined.
module mmio_led_ctrl
  import mmio_led_pkg::*;
#(
  parameter int          NUM_CH    = 8,
  parameter logic [10:0] BASE_ADDR = 11'd15,
  parameter int          PRE_W     = 16
) (
  input  logic              clk,
  input  logic              reset_,
  mmio_led_ctrl_if.slave    bus,
  output logic [NUM_CH-1:0] led
);

  byte_t             r_out;
  byte_t             r_mode;
  byte_t             r_prescale;
  byte_t             r_period;
  logic [NUM_CH-1:0] r_led;
  logic [10:0]       w_ofs;
  logic [2:0]        w_idx;
  logic              w_sel;
  logic              w_wr;
  logic              w_restart;
  logic              w_tick;
  logic              w_phase;
  logic              w_unused;

  // Addresses below BASE_ADDR wrap to large offsets and fall outside the window.
  assign w_ofs     = bus.m_addr - BASE_ADDR;
  assign w_sel     = (w_ofs < 11'(NUM_REGS));
  assign w_idx     = w_ofs[2:0];
  assign w_wr      = bus.m_en & bus.m_wr & w_sel;
  assign w_restart = w_wr & ((w_idx == OFS_PRESCALE) | (w_idx == OFS_PERIOD));

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_out      <= RST_OUT;
      r_mode     <= RST_MODE;
      r_prescale <= RST_PRESCALE;
      r_period   <= RST_PERIOD;
    end else if (w_wr) begin
      case (w_idx)
        OFS_OUT:      r_out      <= bus.m_wr_data;
        OFS_MODE:     r_mode     <= bus.m_wr_data;
        OFS_PRESCALE: r_prescale <= bus.m_wr_data;
        OFS_PERIOD:   r_period   <= bus.m_wr_data;
        default:      ;
      endcase
    end
  end

  led_timebase #(
    .PRE_W (PRE_W)
  ) u_timebase (
    .clk        (clk),
    .reset_     (reset_),
    .i_prescale (r_prescale),
    .i_period   (r_period),
    .i_restart  (w_restart),
    .o_tick     (w_tick),
    .o_phase    (w_phase)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_led <= '1;
    end else begin
      r_led <= r_out[NUM_CH-1:0] ^ (r_mode[NUM_CH-1:0] & {NUM_CH{w_phase}});
    end
  end

  assign led = r_led;

`ifdef MMIO_LED_READBACK_EN
  logic  w_rd;
  byte_t w_rd_mux;
  byte_t r_rd_data;

  assign w_rd = bus.m_en & bus.m_rd & w_sel;

  always_comb begin
    w_rd_mux = 8'h00;
    case (w_idx)
      OFS_OUT:      w_rd_mux = r_out;
      OFS_MODE:     w_rd_mux = r_mode;
      OFS_PRESCALE: w_rd_mux = r_prescale;
      OFS_PERIOD:   w_rd_mux = r_period;
      OFS_STATUS:   w_rd_mux = status_byte(w_phase);
      default:      w_rd_mux = 8'h00;
    endcase
  end

  // Idle cycles return 0 so the bus can OR this with other slaves.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= w_rd ? w_rd_mux : 8'h00;
    end
  end

  assign bus.m_rd_data = r_rd_data;
`else
  assign bus.m_rd_data = 8'h00;
`endif

  assign w_unused = ^{w_tick, bus.m_rd, r_out, r_mode};

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// tb/tb_mmio_led_ctrl.sv - randomized bench with behavioural model for mmio_led_ctrl
module tb_mmio_led_ctrl;

  localparam int          NUM_CH = 8;
  localparam logic [10:0] BASE   = 11'd15;
  localparam int          PRE_W  = 8;
`ifdef MMIO_LED_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_ = 1'b1;
  logic [NUM_CH-1:0] led;
  mmio_led_ctrl_if   bus();

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  mmio_led_ctrl #(
    .NUM_CH    (NUM_CH),
    .BASE_ADDR (BASE),
    .PRE_W     (PRE_W)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus),
    .led    (led)
  );

  always #5 clk = ~clk;

  // Model: registers plus the number of edges since the last timebase restart.
  logic [7:0]        m_regs [4];
  int                m_k;
  logic [NUM_CH-1:0] exp_led;
  logic [7:0]        exp_rd;

  function automatic logic model_phase(input int kk, input logic [7:0] pre, input logic [7:0] per);
    int interval;
    interval = (int'(pre) + 1) * (1 << (PRE_W - 8));
    return (((kk / interval) / (int'(per) + 1)) % 2) == 1;
  endfunction

  function automatic logic [NUM_CH-1:0] model_led(input logic [7:0] o, input logic [7:0] m, input logic ph);
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i] = m[i] ? (o[i] ^ ph) : o[i];
    return r;
  endfunction

  function automatic int ofs_of(input logic [10:0] a);
    return int'(a) - int'(BASE);
  endfunction

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      m_regs[0] <= 8'hFF;
      m_regs[1] <= 8'h00;
      m_regs[2] <= 8'h00;
      m_regs[3] <= 8'h00;
      m_k       <= 0;
      exp_led   <= '1;
      exp_rd    <= 8'h00;
    end else begin
      exp_led <= model_led(m_regs[0], m_regs[1], model_phase(m_k, m_regs[2], m_regs[3]));
      if (RB && bus.m_en && bus.m_rd && ofs_of(bus.m_addr) >= 0 && ofs_of(bus.m_addr) <= 4)
        exp_rd <= (ofs_of(bus.m_addr) == 4) ? {7'b0, model_phase(m_k, m_regs[2], m_regs[3])}
                                            : m_regs[ofs_of(bus.m_addr)];
      else
        exp_rd <= 8'h00;
      if (bus.m_en && bus.m_wr && ofs_of(bus.m_addr) >= 0 && ofs_of(bus.m_addr) <= 3)
        m_regs[ofs_of(bus.m_addr)] <= bus.m_wr_data;
      if (bus.m_en && bus.m_wr && (ofs_of(bus.m_addr) == 2 || ofs_of(bus.m_addr) == 3))
        m_k <= 0;
      else
        m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (led !== exp_led) begin
        failures++;
        $display("FAIL led_cmp t=%0t led=%h expected=%h", $time, led, exp_led);
      end
      checks++;
      if (bus.m_rd_data !== exp_rd) begin
        failures++;
        $display("FAIL rd_cmp t=%0t m_rd_data=%h expected=%h", $time, bus.m_rd_data, exp_rd);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic bus_op(input int ofs, input logic wr, input logic rd, input logic [7:0] d);
    bus.m_addr    = 11'(int'(BASE) + ofs);
    bus.m_wr      = wr;
    bus.m_rd      = rd;
    bus.m_en      = 1'b1;
    bus.m_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    bus.m_en = 1'b0;
    bus.m_wr = 1'b0;
    bus.m_rd = 1'b0;
  endtask

  initial begin
    bus.m_addr = '0; bus.m_wr_data = '0; bus.m_rd = 0; bus.m_wr = 0; bus.m_en = 0;
    #2 reset_ = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    check("reset_led", 8'(led), 8'hFF);
    check("reset_rd", bus.m_rd_data, 8'h00);

    bus_op(0, 1, 0, 8'hA5);
    check("out_same_cycle", 8'(led), 8'hFF);
    @(negedge clk);
    check("out_next_cycle", 8'(led), 8'hA5);
    bus_op(5, 1, 0, 8'h3C);
    @(negedge clk);
    check("out_of_window", 8'(led), 8'hA5);

    bus_op(0, 1, 0, 8'h01);
    bus_op(1, 1, 0, 8'h03);
    bus_op(2, 1, 0, 8'h00);
    bus_op(3, 1, 0, 8'h03);
    repeat (4) @(negedge clk);
    check("blink_phase0", 8'(led), 8'h01);
    @(negedge clk);
    check("blink_phase1", 8'(led), 8'h02);
    repeat (4) @(negedge clk);
    check("blink_phase0_again", 8'(led), 8'h01);

    bus_op(3, 1, 0, 8'h01);
    @(negedge clk);
    check("restart_w1", 8'(led), 8'h01);
    @(negedge clk);
    check("restart_w2", 8'(led), 8'h01);
    @(negedge clk);
    check("restart_toggle", 8'(led), 8'h02);
    repeat (2) @(negedge clk);
    check("restart_back", 8'(led), 8'h01);

    bus_op(2, 1, 0, 8'h5A);
    bus_op(2, 0, 1, 8'h00);
    check("read_prescale", bus.m_rd_data, RB ? 8'h5A : 8'h00);
    @(negedge clk);
    check("read_idle_zero", bus.m_rd_data, 8'h00);
    bus_op(2, 1, 1, 8'h11);
    check("read_old_on_write", bus.m_rd_data, RB ? 8'h5A : 8'h00);
    bus_op(2, 0, 1, 8'h00);
    check("read_new_value", bus.m_rd_data, RB ? 8'h11 : 8'h00);
    bus_op(2, 1, 0, 8'h00);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        bus_op(1, 1, 0, 8'hFF);
        bus_op(3, 1, 0, 8'h01);
        repeat (3) @(negedge clk);
        #2 reset_ = 1'b0;
        #1 check("async_reset_led", 8'(led), 8'hFF);
        @(negedge clk);
        reset_ = 1'b1;
        bus_op(4, 0, 1, 8'h00);
        check("status_after_reset", bus.m_rd_data, 8'h00);
      end
      begin
        int o;
        o = $urandom_range(0, 8) - 2;
        bus.m_addr    = 11'(int'(BASE) + o);
        bus.m_en      = ($urandom_range(0, 3) != 0);
        bus.m_wr      = ($urandom_range(0, 2) == 0);
        bus.m_rd      = ($urandom_range(0, 1) == 0);
        bus.m_wr_data = (o == 2 || o == 3) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end
      @(negedge clk);
    end
    bus.m_en = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_led_ctrl.md
# mmio_led_ctrl

Parametrised memory-mapped LED/output controller for NoobsCPU SoCs, replacing the single hard-wired LED register. Decodes a small register window on the CPU data bus (m_addr/m_wr_data/m_rd_data/m_rd/m_wr/m_en) and drives up to 8 outputs. Each output runs in static mode or in hardware-blink mode from a shared programmable timebase, so the CPU no longer spins delay loops to blink.

## Interface
- NUM_CH, 8: number of output channels, 1..8.
- BASE_ADDR, 11'd15: bus address of register offset 0.
- PRE_W, 16: prescaler width, 8..24.
- clk  in  1  CPU clock (cpu_clk domain); all logic on rising edge.
- reset_  in  1  asynchronous, active-low reset.
- m_addr  in  11  data bus address.
- m_wr_data  in  8  write data.
- m_rd_data  out  8  read data, registered; 0 when not selected.
- m_rd  in  1  read strobe.
- m_wr  in  1  write strobe.
- m_en  in  1  bus enable; qualifies m_rd/m_wr.
- led  out  NUM_CH  channel outputs, registered.

## Operation
- Register map, offset = m_addr - BASE_ADDR; offsets 0..4 selected, others ignored:
  - 0 OUT (rw), reset 8'hFF: static level / blink polarity per channel.
  - 1 MODE (rw), reset 8'h00: bit i = 1 selects blink for channel i.
  - 2 PRESCALE (rw), reset 8'h00.
  - 3 PERIOD (rw), reset 8'h00: half-period in ticks minus 1.
  - 4 STATUS (ro), bit0 = phase, bits 7:1 = 0; writes ignored.
- Bits >= NUM_CH of OUT/MODE are stored but drive nothing.
- Write: m_en & m_wr & selected -> register loads m_wr_data at that edge.
- Timebase: pre_cnt (PRE_W bits) increments every cycle; when pre_cnt == {PRESCALE, (PRE_W-8) ones}, tick = 1 and pre_cnt -> 0. Interval = (PRESCALE+1)*2^(PRE_W-8) cycles.
- Per tick: per_cnt == PERIOD -> per_cnt -> 0, phase toggles; else per_cnt + 1. Phase toggles every (PERIOD+1) ticks.
- Output: led[i] <= MODE[i] ? (OUT[i] ^ phase) : OUT[i]. Same OUT bits on two blink channels = in phase; opposite bits = alternating.
- Write to PRESCALE or PERIOD: pre_cnt, per_cnt and phase all clear to 0 at that edge; write wins over a same-cycle tick.
- MODE/OUT writes never disturb the timebase.

## Timing
- Reset (async assert, sync release handled upstream): led = NUM_CH ones, m_rd_data = 0, pre_cnt = per_cnt = phase = 0, registers at reset values.
- Write -> led change: register updates at edge N, led reflects it at edge N+1.
- Read: m_en & m_rd & selected at edge N -> m_rd_data valid after edge N until next edge; otherwise m_rd_data = 0 (bus is OR-muxed).
- Read and write to same offset in same cycle: read returns old value.
- Phase toggle at edge N -> led toggles at edge N+1.
- m_rd and m_wr both high: both performed.
- Counters wrap naturally; no overflow outside the rules above.

## Configuration
- MMIO_LED_READBACK_EN defined: offsets 0..4 readable as above.
- Undefined: m_rd_data tied to 0, no read register; writes and blinking unchanged.

## Structure
- Shared package/include mmio_led_pkg: register offsets (OFS_OUT=0, OFS_MODE=1, OFS_PRESCALE=2, OFS_PERIOD=3, OFS_STATUS=4), reset values, NUM_REGS=5.
- One sub-module: led_timebase (pre_cnt, per_cnt, phase; inputs prescale, period, restart; outputs tick, phase).
- Top holds decode, registers, readback mux, led register.

## Test plan
- Reset: drop reset_ mid-blink -> led = 8'hFF, phase = 0 immediately; after release STATUS reads 0.
- Static write: write OUT=8'hA5 at BASE_ADDR -> led = 8'hA5 one cycle later; write to BASE_ADDR+5 -> no change.
- Blink (PRE_W=8): PRESCALE=0, PERIOD=3, MODE=8'h03, OUT=8'h01 -> led[0]/led[1] toggle in opposition every 4 cycles, led[7:2] static.
- Restart: write PERIOD=1 mid-count on a tick cycle -> phase=0, first toggle exactly 2 ticks after write.
- Readback: write PRESCALE=8'h5A, read offset 2 -> m_rd_data=8'h5A for one cycle, then 0; same-cycle write 8'h11 + read -> returns 8'h5A.
- Macro off: any read -> m_rd_data = 0; blink scenario unchanged.
